dco_freq_ctrl: RTL and testbench
================================

# dco_freq_ctrl

Sequencer for the behavioural/silicon DCO in the DVFS socket. It accepts frequency-change requests over a valid/ready handshake and drives the DCO control pins. The DCO code is ramped one step at a time with programmable dwell and settle intervals. The socket clock is parked on the external clock (CLK_SEL) while the DCO is waking up or being shut down. The block sits between the DVFS policy logic and the DCO macro and runs on the reference clock.

## Interface
- STEP_CYCLES, 16, reference cycles spent at each intermediate code during a ramp (≥1)
- SETTLE_CYCLES, 64, reference cycles for DCO wake-up, post-ramp settling and clock switch-over (≥1)
- CLK  in  1  reference clock; all state is on its rising edge
- RSTN  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  block can accept a request
- REQ_EN  in  1  1 = DCO on at REQ_CODE, 0 = DCO off
- REQ_CODE  in  8  target code {FREQ_SEL, CC_SEL}; 0 = fastest, 255 = slowest
- REQ_FC  in  6  fine-cap setting
- REQ_DIV  in  3  divider setting
- DCO_EN  out  1  DCO enable
- DCO_FREQ_SEL  out  2  current code [7:6]
- DCO_CC_SEL  out  6  current code [5:0]
- DCO_FC_SEL  out  6  registered REQ_FC
- DCO_DIV_SEL  out  3  registered REQ_DIV
- DCO_CLK_SEL  out  1  1 = external clock selected, 0 = DCO clock
- BUSY  out  1  high in any state other than OFF/ON
- DONE  out  1  one-cycle pulse when a request completes

## Operation
- The request handshake fires when REQ_VALID && REQ_READY. REQ_READY = 1 only in OFF and ON.
- On acceptance, all REQ_* fields are latched. DCO_FC_SEL and DCO_DIV_SEL update the cycle after acceptance. The target code is held internally.
- Reset values: state OFF, code 8'hFF, DCO_EN 0, DCO_CLK_SEL 1, DCO_FC_SEL 0, DCO_DIV_SEL 0, REQ_READY 1, BUSY 0, DONE 0.
- **OFF**: DCO_EN 0, code 8'hFF, DCO_CLK_SEL 1.
  - Accepted REQ_EN=1 → WAKE.
  - Accepted REQ_EN=0 → stay in OFF, DONE on the next cycle.
- **WAKE**: DCO_EN 1 and code 8'hFF from the first WAKE cycle. Stay SETTLE_CYCLES cycles, then → RAMP.
- **RAMP**: code moves ±1 toward the target every STEP_CYCLES cycles (first step after STEP_CYCLES cycles in RAMP). When the code equals the target → SETTLE.
  - If the code already equals the target on entry, go straight to SETTLE.
- **SETTLE**: stay SETTLE_CYCLES cycles, then DCO_CLK_SEL ← 0, DONE pulse, → ON.
- **ON**: DCO_EN 1, DCO_CLK_SEL 0.
  - Accepted REQ_EN=1 with target ≠ code → RAMP. The DCO stays selected during the ramp.
  - Accepted REQ_EN=1 with target = code → DONE on the next cycle, stay in ON.
  - Accepted REQ_EN=0 → PARK.
- **PARK**: DCO_CLK_SEL 1 from the first PARK cycle. After SETTLE_CYCLES cycles: DCO_EN ← 0, code ← 8'hFF, DONE pulse, → OFF.
- Arithmetic:
  - Code steps are saturating 8-bit and never pass the target.
  - Ramp direction: target < code → decrement (faster); target > code → increment.
- Boundary conditions:
  - Requests in busy states are not accepted and are held by the requester.
  - REQ_VALID in the same cycle as a DONE pulse is not accepted; REQ_READY rises the cycle after DONE.
  - Reset asserted mid-ramp or mid-park forces all reset values asynchronously.

## Timing
- Cycle 0 is the acceptance edge; Δ = |target − start code|.
- OFF → on: DONE and DCO_CLK_SEL fall at cycle 1 + SETTLE_CYCLES + Δ·STEP_CYCLES + SETTLE_CYCLES, with start code 255.
- ON → ON, Δ > 0: DONE at cycle 1 + Δ·STEP_CYCLES + SETTLE_CYCLES.
- Δ = 0 in ON, or REQ_EN=0 in OFF: DONE at cycle 1.
- ON → OFF: DCO_CLK_SEL rises at cycle 1; DONE and DCO_EN fall at cycle 1 + SETTLE_CYCLES.
- DONE is high for exactly 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs except REQ_READY, which is state-decoded only.

## Structure
- Package dco_ctrl_pkg holds:
  - state enum {OFF, WAKE, RAMP, SETTLE, ON, PARK}
  - DCO_CODE_W = 8
  - CODE_SLOWEST = 8'hFF
  - FC_W = 6, DIV_W = 3
- Sub-module dco_ctrl_timer: loadable down-counter with load value and a one-cycle expire output.
  - Width is $clog2(max(STEP_CYCLES, SETTLE_CYCLES)+1).
  - It is shared by WAKE, RAMP, SETTLE and PARK.
- Top level: FSM, code register, request latch.

## Test plan
All scenarios use STEP_CYCLES=4, SETTLE_CYCLES=8.
- Reset release, idle for 10 cycles → code 8'hFF, DCO_EN 0, DCO_CLK_SEL 1, REQ_READY 1, DONE never asserted.
- OFF, request EN=1 code 250 → DCO_EN rises at cycle 1; code 254 at cycle 13, 250 at cycle 29; DONE and DCO_CLK_SEL=0 at cycle 37.
- ON at 250, request code 252 → code 251 at cycle 5, 252 at cycle 9, DONE at cycle 17. Then request code 252 again → DONE at cycle 1 with no code change.
- ON, request EN=0 → DCO_CLK_SEL 1 at cycle 1; DONE, DCO_EN 0 and code 8'hFF at cycle 9; REQ_READY 1 at cycle 10.
- REQ_VALID held during a ramp with a new code → not accepted until the cycle after DONE; the second ramp then starts from the first target.
- RSTN pulsed low mid-RAMP at code 252 → outputs return to reset values without waiting for a clock edge; the next request restarts from WAKE.

Source files
------------

// File: rtl/dco_ctrl_pkg.sv
// dco_ctrl_pkg: shared types and constants for the DCO frequency sequencer.
//   - dco_state_e  : sequencer states
//   - DCO_CODE_W   : width of the {FREQ_SEL, CC_SEL} code
//   - CODE_SLOWEST : code the DCO is parked at while off / waking
//   - FC_W, DIV_W  : fine-cap and divider field widths
//   - step_toward(): one saturating code step toward a target
package dco_ctrl_pkg;

    localparam int DCO_CODE_W = 8;
    localparam int FC_W       = 6;
    localparam int DIV_W      = 3;

    localparam logic [DCO_CODE_W-1:0] CODE_SLOWEST = 8'hFF;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAKE,
        ST_RAMP,
        ST_SETTLE,
        ST_ON,
        ST_PARK
    } dco_state_e;

    // One step toward tgt; never overshoots and never wraps past 0 / 255.
    function automatic logic [DCO_CODE_W-1:0] step_toward(
        input logic [DCO_CODE_W-1:0] cur,
        input logic [DCO_CODE_W-1:0] tgt
    );
        logic [DCO_CODE_W-1:0] nxt;
        nxt = cur;
        if ((tgt < cur) && (cur != '0)) begin
            nxt = cur - DCO_CODE_W'(1);
        end else if ((tgt > cur) && (cur != CODE_SLOWEST)) begin
            nxt = cur + DCO_CODE_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dco_ctrl_timer.sv
// dco_ctrl_timer: loadable down-counter shared by all timed sequencer states.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : number of cycles until the next state change
//   expire     : high for the last cycle of the loaded interval, so the
//                owner changes state on the edge that ends the interval
module dco_ctrl_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter rests at 0 once expired, so this is a single-cycle pulse.
    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/dco_freq_ctrl.sv
// dco_freq_ctrl: DCO wake / ramp / settle / park sequencer.
//   CLK, RSTN           : reference clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY : request handshake; READY only when idle (OFF/ON)
//   REQ_EN, REQ_CODE    : DCO on at target code, or DCO off
//   REQ_FC, REQ_DIV     : fine-cap / divider, forwarded to the DCO pins
//   DCO_*               : DCO macro control pins (all registered)
//   BUSY                : sequencing in progress
//   DONE                : one-cycle pulse when a request completes
// An accepted request is latched on the acceptance edge and acted on one
// edge later, so every visible effect starts at cycle 1.
module dco_freq_ctrl
    import dco_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_EN,
    input  logic [DCO_CODE_W-1:0] REQ_CODE,
    input  logic [FC_W-1:0]       REQ_FC,
    input  logic [DIV_W-1:0]      REQ_DIV,
    output logic                  DCO_EN,
    output logic [1:0]            DCO_FREQ_SEL,
    output logic [5:0]            DCO_CC_SEL,
    output logic [FC_W-1:0]       DCO_FC_SEL,
    output logic [DIV_W-1:0]      DCO_DIV_SEL,
    output logic                  DCO_CLK_SEL,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int TMR_MAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] STEP_LD   = TMR_W'(STEP_CYCLES);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES);

    dco_state_e            state_q, state_d;
    logic [DCO_CODE_W-1:0] code_q, code_d;
    logic [DCO_CODE_W-1:0] tgt_q, tgt_d;
    logic                  req_en_q, req_en_d;
    logic [FC_W-1:0]       req_fc_q, req_fc_d;
    logic [DIV_W-1:0]      req_div_q, req_div_d;
    logic                  pend_q, pend_d;
    logic                  dco_en_q, dco_en_d;
    logic                  clk_sel_q, clk_sel_d;
    logic [FC_W-1:0]       fc_q, fc_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_expire;
    logic [DCO_CODE_W-1:0] code_step;

    dco_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (RSTN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Ready stays low while a latched request is pending and during the
    // DONE cycle, so a request presented alongside DONE is not taken.
    assign REQ_READY = ((state_q == ST_OFF) || (state_q == ST_ON)) && !pend_q && !done_q;
    assign accept    = REQ_VALID && REQ_READY;
    assign code_step = step_toward(code_q, tgt_q);

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        tgt_d     = tgt_q;
        req_en_d  = req_en_q;
        req_fc_d  = req_fc_q;
        req_div_d = req_div_q;
        pend_d    = accept;
        dco_en_d  = dco_en_q;
        clk_sel_d = clk_sel_q;
        fc_d      = fc_q;
        div_d     = div_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = STEP_LD;

        if (accept) begin
            tgt_d     = REQ_CODE;
            req_en_d  = REQ_EN;
            req_fc_d  = REQ_FC;
            req_div_d = REQ_DIV;
        end

        case (state_q)
            ST_OFF: begin
                if (pend_q) begin
                    fc_d  = req_fc_q;
                    div_d = req_div_q;
                    if (req_en_q) begin
                        state_d  = ST_WAKE;
                        dco_en_d = 1'b1;
                        code_d   = CODE_SLOWEST;
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_WAKE: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (code_q == tgt_q) begin
                        state_d = ST_SETTLE;
                        tmr_val = SETTLE_LD;
                    end else begin
                        state_d = ST_RAMP;
                        tmr_val = STEP_LD;
                    end
                end
            end
            ST_RAMP: begin
                if (tmr_expire) begin
                    code_d   = code_step;
                    tmr_load = 1'b1;
                    // Leave on the same edge the final step lands.
                    if (code_step == tgt_q) begin
                        state_d = ST_SETTLE;
                        tmr_val = SETTLE_LD;
                    end else begin
                        tmr_val = STEP_LD;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_expire) begin
                    state_d   = ST_ON;
                    clk_sel_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            ST_ON: begin
                if (pend_q) begin
                    fc_d  = req_fc_q;
                    div_d = req_div_q;
                    if (!req_en_q) begin
                        state_d   = ST_PARK;
                        clk_sel_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = SETTLE_LD;
                    end else if (tgt_q == code_q) begin
                        done_d = 1'b1;
                    end else begin
                        // DCO clock stays selected through an in-band ramp.
                        state_d  = ST_RAMP;
                        tmr_load = 1'b1;
                        tmr_val  = STEP_LD;
                    end
                end
            end
            ST_PARK: begin
                if (tmr_expire) begin
                    state_d  = ST_OFF;
                    dco_en_d = 1'b0;
                    code_d   = CODE_SLOWEST;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        busy_d = !((state_d == ST_OFF) || (state_d == ST_ON));
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_OFF;
            code_q    <= CODE_SLOWEST;
            tgt_q     <= CODE_SLOWEST;
            req_en_q  <= 1'b0;
            req_fc_q  <= '0;
            req_div_q <= '0;
            pend_q    <= 1'b0;
            dco_en_q  <= 1'b0;
            clk_sel_q <= 1'b1;
            fc_q      <= '0;
            div_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            tgt_q     <= tgt_d;
            req_en_q  <= req_en_d;
            req_fc_q  <= req_fc_d;
            req_div_q <= req_div_d;
            pend_q    <= pend_d;
            dco_en_q  <= dco_en_d;
            clk_sel_q <= clk_sel_d;
            fc_q      <= fc_d;
            div_q     <= div_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign DCO_EN       = dco_en_q;
    assign DCO_FREQ_SEL = code_q[7:6];
    assign DCO_CC_SEL   = code_q[5:0];
    assign DCO_FC_SEL   = fc_q;
    assign DCO_DIV_SEL  = div_q;
    assign DCO_CLK_SEL  = clk_sel_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;

endmodule

// File: tb/tb_dco_freq_ctrl.sv
// tb_dco_freq_ctrl: bench for dco_freq_ctrl with STEP_CYCLES=4, SETTLE_CYCLES=8.
// Expected outputs per cycle come from a timeline model written directly in
// terms of the request timing rules (cycle k after the acceptance edge).
module tb_dco_freq_ctrl;

    localparam int ST = 4;
    localparam int SE = 8;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic       REQ_EN;
    logic [7:0] REQ_CODE;
    logic [5:0] REQ_FC;
    logic [2:0] REQ_DIV;
    logic       DCO_EN;
    logic [1:0] DCO_FREQ_SEL;
    logic [5:0] DCO_CC_SEL;
    logic [5:0] DCO_FC_SEL;
    logic [2:0] DCO_DIV_SEL;
    logic       DCO_CLK_SEL;
    logic       BUSY;
    logic       DONE;

    dco_freq_ctrl #(
        .STEP_CYCLES   (ST),
        .SETTLE_CYCLES (SE)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_EN       (REQ_EN),
        .REQ_CODE     (REQ_CODE),
        .REQ_FC       (REQ_FC),
        .REQ_DIV      (REQ_DIV),
        .DCO_EN       (DCO_EN),
        .DCO_FREQ_SEL (DCO_FREQ_SEL),
        .DCO_CC_SEL   (DCO_CC_SEL),
        .DCO_FC_SEL   (DCO_FC_SEL),
        .DCO_DIV_SEL  (DCO_DIV_SEL),
        .DCO_CLK_SEL  (DCO_CLK_SEL),
        .BUSY         (BUSY),
        .DONE         (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit en;
        int code;
        int fc;
        int dv;
        int exp_done;
    } vec_t;

    vec_t tbl[9];

    int n_vec = 0;
    int n_err = 0;
    int cur_k = 0;

    // Model state: what the DCO is doing between requests.
    bit m_on   = 1'b0;
    int m_code = 255;
    int m_fc   = 0;
    int m_div  = 0;

    function automatic int dco_code();
        return int'({DCO_FREQ_SEL, DCO_CC_SEL});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s k=%0d: got %0d, expected %0d", name, cur_k, act, exp);
        end
    endtask

    // Timeline of one request: expected outputs at cycle k after acceptance.
    function automatic void model(input int k, input bit on0, input int c0,
                                  input bit en, input int tgt,
                                  output int t_done, output int code,
                                  output bit den, output bit csel, output bit busy);
        int d, dir, n, t_ramp;
        d      = (tgt > c0) ? tgt - c0 : c0 - tgt;
        dir    = (tgt > c0) ? 1 : -1;
        t_ramp = 1;
        code   = c0;
        if (!on0 && !en) begin
            t_done = 1; den = 0; csel = 1; busy = 0; code = 255;
        end else if (!on0) begin
            t_ramp = 1 + SE;
            t_done = t_ramp + d * ST + SE;
            den    = (k >= 1);
            csel   = (k < t_done);
            busy   = (k >= 1) && (k < t_done);
        end else if (en) begin
            t_done = (d == 0) ? 1 : 1 + d * ST + SE;
            den    = 1;
            csel   = 0;
            busy   = (d != 0) && (k >= 1) && (k < t_done);
        end else begin
            t_done = 1 + SE;
            den    = (k < t_done);
            csel   = (k >= 1);
            busy   = (k >= 1) && (k < t_done);
            code   = (k >= t_done) ? 255 : c0;
        end
        if (en && k >= t_ramp) begin
            n = (k - t_ramp) / ST;
            if (n > d) n = d;
            code = c0 + dir * n;
        end
    endfunction

    // Waits (bounded) for READY at a falling edge, then presents a request.
    task automatic issue(input bit en, input int code, input int fc, input int dv);
        int w;
        w = 0;
        while (REQ_READY !== 1'b1 && w < 3000) begin
            @(negedge CLK);
            w++;
        end
        chk("ready_before_req", int'(REQ_READY), 1);
        REQ_VALID = 1'b1;
        REQ_EN    = en;
        REQ_CODE  = code[7:0];
        REQ_FC    = fc[5:0];
        REQ_DIV   = dv[2:0];
    endtask

    // Checks every cycle of the request accepted on the next rising edge.
    // With hold set, REQ_VALID stays high and the fields switch to a new
    // request that must wait until the block is ready again.
    task automatic expect_txn(input bit en, input int tgt, input int fc, input int dv,
                              input bit hold, input bit hen, input int hcode,
                              input int hfc, input int hdv, output int obs_done);
        int  t_done, code_e;
        bit  den_e, csel_e, busy_e;
        bit  on0;
        int  c0;
        on0      = m_on;
        c0       = m_code;
        obs_done = -1;
        @(posedge CLK);
        #1;
        if (hold) begin
            REQ_EN   = hen;
            REQ_CODE = hcode[7:0];
            REQ_FC   = hfc[5:0];
            REQ_DIV  = hdv[2:0];
        end else begin
            REQ_VALID = 1'b0;
        end
        model(0, on0, c0, en, tgt, t_done, code_e, den_e, csel_e, busy_e);
        for (int k = 0; k <= t_done + 1; k++) begin
            @(negedge CLK);
            cur_k = k;
            model(k, on0, c0, en, tgt, t_done, code_e, den_e, csel_e, busy_e);
            chk("code",    dco_code(),         code_e);
            chk("dco_en",  int'(DCO_EN),       int'(den_e));
            chk("clk_sel", int'(DCO_CLK_SEL),  int'(csel_e));
            chk("busy",    int'(BUSY),         int'(busy_e));
            chk("done",    int'(DONE),         (k == t_done) ? 1 : 0);
            chk("ready",   int'(REQ_READY),    (k > t_done) ? 1 : 0);
            chk("fc_sel",  int'(DCO_FC_SEL),   (k >= 1) ? fc : m_fc);
            chk("div_sel", int'(DCO_DIV_SEL),  (k >= 1) ? dv : m_div);
            if (DONE === 1'b1 && obs_done < 0) obs_done = k;
        end
        m_on   = en;
        m_code = en ? tgt : 255;
        m_fc   = fc;
        m_div  = dv;
    endtask

    initial begin
        int obs, w, c;
        bit found;

        tbl[0] = '{en: 1'b1, code: 250, fc: 5,  dv: 1, exp_done: 37};
        tbl[1] = '{en: 1'b1, code: 252, fc: 9,  dv: 2, exp_done: 17};
        tbl[2] = '{en: 1'b1, code: 252, fc: 12, dv: 3, exp_done: 1};
        tbl[3] = '{en: 1'b0, code: 0,   fc: 33, dv: 4, exp_done: 9};
        tbl[4] = '{en: 1'b0, code: 7,   fc: 40, dv: 5, exp_done: 1};
        tbl[5] = '{en: 1'b1, code: 255, fc: 63, dv: 7, exp_done: 17};
        tbl[6] = '{en: 1'b1, code: 0,   fc: 1,  dv: 6, exp_done: 1029};
        tbl[7] = '{en: 1'b1, code: 3,   fc: 2,  dv: 0, exp_done: 21};
        tbl[8] = '{en: 1'b0, code: 0,   fc: 17, dv: 3, exp_done: 9};

        RSTN = 1'b0; REQ_VALID = 1'b0; REQ_EN = 1'b0;
        REQ_CODE = '0; REQ_FC = '0; REQ_DIV = '0;

        // Reset state, then 10 idle cycles with nothing happening.
        repeat (2) @(negedge CLK);
        chk("rst_code",  dco_code(), 255);
        chk("rst_clk",   int'(DCO_CLK_SEL), 1);
        RSTN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            cur_k = i;
            chk("idle_code",  dco_code(), 255);
            chk("idle_en",    int'(DCO_EN), 0);
            chk("idle_clk",   int'(DCO_CLK_SEL), 1);
            chk("idle_ready", int'(REQ_READY), 1);
            chk("idle_done",  int'(DONE), 0);
            chk("idle_busy",  int'(BUSY), 0);
            chk("idle_fc",    int'(DCO_FC_SEL), 0);
            chk("idle_div",   int'(DCO_DIV_SEL), 0);
        end

        // Directed request table: per-cycle model plus absolute DONE cycle.
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].en, tbl[i].code, tbl[i].fc, tbl[i].dv);
            expect_txn(tbl[i].en, tbl[i].code, tbl[i].fc, tbl[i].dv, 1'b0, 1'b0, 0, 0, 0, obs);
            cur_k = i;
            chk("tbl_done_cycle", obs, tbl[i].exp_done);
        end

        // Request held through a ramp: taken only after DONE, ramps from 253.
        issue(1'b1, 250, 3, 3);
        expect_txn(1'b1, 250, 3, 3, 1'b0, 1'b0, 0, 0, 0, obs);
        issue(1'b1, 253, 20, 1);
        expect_txn(1'b1, 253, 20, 1, 1'b1, 1'b1, 251, 44, 6, obs);
        chk("hold_first_done", obs, 21);
        expect_txn(1'b1, 251, 44, 6, 1'b0, 1'b0, 0, 0, 0, obs);
        chk("hold_second_done", obs, 17);

        // Reset mid-ramp at code 252 acts without a clock edge.
        issue(1'b1, 255, 11, 2);
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        found = 1'b0;
        w = 0;
        while (!found && w < 100) begin
            @(negedge CLK);
            w++;
            if (dco_code() == 252) found = 1'b1;
        end
        chk("reach_252", int'(found), 1);
        #2 RSTN = 1'b0;
        #1;
        chk("arst_code",  dco_code(), 255);
        chk("arst_en",    int'(DCO_EN), 0);
        chk("arst_clk",   int'(DCO_CLK_SEL), 1);
        chk("arst_ready", int'(REQ_READY), 1);
        chk("arst_busy",  int'(BUSY), 0);
        chk("arst_done",  int'(DONE), 0);
        chk("arst_fc",    int'(DCO_FC_SEL), 0);
        chk("arst_div",   int'(DCO_DIV_SEL), 0);
        @(negedge CLK);
        RSTN = 1'b1;
        m_on = 1'b0; m_code = 255; m_fc = 0; m_div = 0;
        @(negedge CLK);
        issue(1'b1, 253, 7, 5);
        expect_txn(1'b1, 253, 7, 5, 1'b0, 1'b0, 0, 0, 0, obs);
        chk("post_rst_done", obs, 1 + SE + 2 * ST + SE);

        // Randomized requests against the timeline model.
        for (int i = 0; i < 30; i++) begin
            bit en;
            int fc, dv;
            repeat ($urandom_range(0, 3)) begin
                @(negedge CLK);
                chk("gap_done",  int'(DONE), 0);
                chk("gap_ready", int'(REQ_READY), 1);
            end
            fc = int'($urandom_range(0, 63));
            dv = int'($urandom_range(0, 7));
            if (m_on) begin
                en = ($urandom_range(0, 5) != 0);
                c  = m_code + int'($urandom_range(0, 10)) - 5;
            end else begin
                en = ($urandom_range(0, 4) != 0);
                c  = 255 - int'($urandom_range(0, 6));
            end
            if (c < 0)   c = 0;
            if (c > 255) c = 255;
            issue(en, c, fc, dv);
            expect_txn(en, c, fc, dv, 1'b0, 1'b0, 0, 0, 0, obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
